// File: rtl/sd_data_tx_ctrl.sv
// SD DAT write-path sequencer, 1-bit bus: start bit, MSB-first block data,
// CRC-16 (x^16+x^12+x^5+1) and end bit, paced by the bit-rate strobe.
module sd_data_tx_ctrl #(
  parameter int BLOCK_BYTES = 512,
  parameter int CNT_W       = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        bit_en,
  input  logic        start,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        dat_out,
  output logic        dat_oe,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] crc_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_CRC,
    S_END
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BLOCK_BYTES - 1);
  localparam logic [15:0]      POLY      = 16'h1021;

  state_t           state_q, state_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [15:0]      crc_q, crc_d;
  logic [15:0]      crc_out_q, crc_out_d;
  logic [3:0]       crc_cnt_q, crc_cnt_d;
  logic             end_ph_q, end_ph_d;
  logic             dat_out_q, dat_out_d;
  logic             dat_oe_q, dat_oe_d;

  logic             need_byte;
  logic             tx_bit;
  logic             tx_take;
  logic [15:0]      crc_nx;

  function automatic logic [15:0] crc_step(
    input logic [15:0] c,
    input logic        b
  );
    logic inv;
    inv = b ^ c[15];
    return {c[14:0], 1'b0} ^ (inv ? POLY : 16'h0000);
  endfunction

  assign need_byte  = (state_q == S_DATA) && (bit_idx_q == 3'd7);
  assign data_ready = need_byte && bit_en && data_valid;
  // Pulses are suppressed under reset so an abandoned block reports nothing.
  assign error      = !RST && need_byte && bit_en && !data_valid;
  assign done       = !RST && (state_q == S_END) && end_ph_q && bit_en;
  assign busy       = (state_q != S_IDLE);
  assign dat_out    = dat_out_q;
  assign dat_oe     = dat_oe_q;
  assign crc_out    = crc_out_q;
  assign crc_nx     = crc_step(crc_q, tx_bit);

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;
    crc_d      = crc_q;
    crc_out_d  = crc_out_q;
    crc_cnt_d  = crc_cnt_q;
    end_ph_d   = end_ph_q;
    dat_out_d  = dat_out_q;
    dat_oe_d   = dat_oe_q;
    tx_bit     = 1'b1;
    tx_take    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        dat_oe_d  = 1'b0;
        dat_out_d = 1'b1;
        if (start) begin
          crc_d      = '0;
          byte_cnt_d = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_en) begin
          dat_oe_d  = 1'b1;
          dat_out_d = 1'b0;
          bit_idx_d = 3'd7;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_en) begin
          if (bit_idx_q == 3'd7) begin
            if (data_valid) begin
              shreg_d = data_in;
              tx_bit  = data_in[7];
              tx_take = 1'b1;
            end else begin
              dat_oe_d  = 1'b0;
              dat_out_d = 1'b1;
              state_d   = S_IDLE;
            end
          end else begin
            tx_bit  = shreg_q[bit_idx_q];
            tx_take = 1'b1;
          end
        end
      end
      S_CRC: begin
        if (bit_en) begin
          dat_out_d = crc_out_q[crc_cnt_q];
          crc_cnt_d = crc_cnt_q - 4'd1;
          if (crc_cnt_q == 4'd0) begin
            end_ph_d = 1'b0;
            state_d  = S_END;
          end
        end
      end
      S_END: begin
        if (bit_en) begin
          dat_out_d = 1'b1;
          if (!end_ph_q) begin
            end_ph_d = 1'b1;
          end else begin
            dat_oe_d = 1'b0;
            state_d  = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (tx_take) begin
      dat_out_d = tx_bit;
      crc_d     = crc_nx;
      bit_idx_d = bit_idx_q - 3'd1;
      if (bit_idx_q == 3'd0) begin
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
        // Last bit of the block: the updated LFSR is the frame CRC.
        if (byte_cnt_q == LAST_BYTE) begin
          crc_out_d = crc_nx;
          crc_cnt_d = 4'd15;
          state_d   = S_CRC;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      bit_idx_q  <= 3'd7;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
      crc_q      <= '0;
      crc_out_q  <= '0;
      crc_cnt_q  <= '0;
      end_ph_q   <= 1'b0;
      dat_out_q  <= 1'b1;
      dat_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
      crc_q      <= crc_d;
      crc_out_q  <= crc_out_d;
      crc_cnt_q  <= crc_cnt_d;
      end_ph_q   <= end_ph_d;
      dat_out_q  <= dat_out_d;
      dat_oe_q   <= dat_oe_d;
    end
  end

endmodule
